// File: rtl/apb_global_pkg.sv
// Shared types and default sizes for the APB master and its helpers.
package apb_global_pkg;

    localparam int APB_ADDR_WIDTH   = 32;
    localparam int APB_DATA_WIDTH   = 32;
    localparam int APB_NO_OF_SLAVES = 1;

    typedef enum logic [1:0] {
        APB_IDLE   = 2'd0,
        APB_SETUP  = 2'd1,
        APB_ACCESS = 2'd2
    } apb_fsm_state_e;

    // Width of the slave index field; kept at one bit minimum so vectors stay legal.
    function automatic int apb_sel_width(input int n_slaves);
        return (n_slaves > 1) ? $clog2(n_slaves) : 1;
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS wait states and flags the cycle that would reach the limit.
module apb_wait_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Clear wins over counting; the count saturates at the limit.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != CW'(LIMIT))) begin
            count_d = count_q + CW'(1);
        end
    end

    // Counter register, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = enable && (count_q == CW'(LIMIT - 1));

endmodule

// File: rtl/apb_master_fsm.sv
// APB master: turns upstream valid/ready requests into IDLE/SETUP/ACCESS transfers.
module apb_master_fsm
    import apb_global_pkg::*;
#(
    parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH     = APB_DATA_WIDTH,
    parameter int NO_OF_SLAVES   = APB_NO_OF_SLAVES,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      pclk,
    input  logic                      preset_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    input  logic [DATA_WIDTH/8-1:0]   req_strb,
    input  logic [2:0]                req_prot,
    output logic                      rsp_valid,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      rsp_slverr,
    output logic                      rsp_timeout,
    output logic [NO_OF_SLAVES-1:0]   pselx,
    output logic                      penable,
    output logic                      pwrite,
    output logic [ADDR_WIDTH-1:0]     paddr,
    output logic [DATA_WIDTH-1:0]     pwdata,
    output logic [DATA_WIDTH/8-1:0]   pstrb,
    output logic [2:0]                pprot,
    input  logic                      pready,
    input  logic                      pslverr,
    input  logic [DATA_WIDTH-1:0]     prdata
);

    localparam int SEL_W  = apb_sel_width(NO_OF_SLAVES);
    localparam int STRB_W = DATA_WIDTH / 8;

    apb_fsm_state_e state_q, state_d;

    logic [SEL_W-1:0]      sel_q,         sel_d;
    logic [ADDR_WIDTH-1:0] paddr_q,       paddr_d;
    logic                  pwrite_q,      pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q,      pwdata_d;
    logic [STRB_W-1:0]     pstrb_q,       pstrb_d;
    logic [2:0]            pprot_q,       pprot_d;
    logic                  rsp_valid_q,   rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q,   rsp_rdata_d;
    logic                  rsp_slverr_q,  rsp_slverr_d;
    logic                  rsp_timeout_q, rsp_timeout_d;

    logic [SEL_W-1:0] req_sel;
    logic             decode_err;
    logic             accept;
    logic             timer_enable;
    logic             timer_expired;

    assign req_ready = (state_q == APB_IDLE) && preset_n;
    assign accept    = req_valid && req_ready;

    // Slave index comes from the top address bits; out-of-range indices are decode errors.
    always_comb begin
        req_sel = req_addr[ADDR_WIDTH-1 -: SEL_W];
        if (NO_OF_SLAVES == 1) begin
            req_sel = '0;
        end
        decode_err = ({1'b0, req_sel} >= (SEL_W + 1)'(NO_OF_SLAVES));
    end

    assign timer_enable = (state_q == APB_ACCESS) && !pready;

    apb_wait_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk     (pclk),
        .rst_n   (preset_n),
        .clear   (accept),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    // State register.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q <= APB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a decode error never leaves IDLE; completion beats timeout in ACCESS.
    always_comb begin
        state_d = state_q;
        case (state_q)
            APB_IDLE:   if (accept && !decode_err) state_d = APB_SETUP;
            APB_SETUP:  state_d = APB_ACCESS;
            APB_ACCESS: if (pready || timer_expired) state_d = APB_IDLE;
            default:    state_d = APB_IDLE;
        endcase
    end

    // Bus control outputs decoded straight from the state so reset drops them at once.
    always_comb begin
        pselx   = '0;
        penable = 1'b0;
        if (state_q != APB_IDLE) begin
            pselx = NO_OF_SLAVES'(1) << sel_q;
        end
        if (state_q == APB_ACCESS) begin
            penable = 1'b1;
        end
    end

    // Capture the request at acceptance and build the one-cycle response.
    always_comb begin
        sel_d         = sel_q;
        paddr_d       = paddr_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        pprot_d       = pprot_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = '0;
        rsp_slverr_d  = 1'b0;
        rsp_timeout_d = 1'b0;
        if (accept) begin
            sel_d    = req_sel;
            paddr_d  = req_addr;
            pwrite_d = req_write;
            pwdata_d = req_write ? req_wdata : '0;
            pstrb_d  = req_write ? req_strb : '0;
            pprot_d  = req_prot;
        end
        if (accept && decode_err) begin
            rsp_valid_d  = 1'b1;
            rsp_slverr_d = 1'b1;
        end else if ((state_q == APB_ACCESS) && pready) begin
            rsp_valid_d  = 1'b1;
            rsp_slverr_d = pslverr;
            rsp_rdata_d  = pwrite_q ? '0 : prdata;
        end else if ((state_q == APB_ACCESS) && timer_expired) begin
            rsp_valid_d   = 1'b1;
            rsp_timeout_d = 1'b1;
        end
    end

    // Request and response registers; everything returns to zero on reset.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            sel_q         <= '0;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            pprot_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_slverr_q  <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            sel_q         <= sel_d;
            paddr_q       <= paddr_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            pprot_q       <= pprot_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_slverr_q  <= rsp_slverr_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign paddr       = paddr_q;
    assign pwrite      = pwrite_q;
    assign pwdata      = pwdata_q;
    assign pstrb       = pstrb_q;
    assign pprot       = pprot_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_slverr  = rsp_slverr_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_fsm.sv
// Testbench for apb_master_fsm: transaction-level reference model plus directed literal checks.
module tb_apb_master_fsm;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 3;
    localparam int TO = 16;
    localparam int SW = DW / 8;

    logic          pclk = 1'b0;
    logic          preset_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [SW-1:0] req_strb;
    logic [2:0]    req_prot;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_slverr;
    logic          rsp_timeout;
    logic [NS-1:0] pselx;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [SW-1:0] pstrb;
    logic [2:0]    pprot;
    logic          pready;
    logic          pslverr;
    logic [DW-1:0] prdata;

    apb_master_fsm #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .NO_OF_SLAVES   (NS),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .pclk        (pclk),
        .preset_n    (preset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_strb    (req_strb),
        .req_prot    (req_prot),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_slverr  (rsp_slverr),
        .rsp_timeout (rsp_timeout),
        .pselx       (pselx),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .pstrb       (pstrb),
        .pprot       (pprot),
        .pready      (pready),
        .pslverr     (pslverr),
        .prdata      (prdata)
    );

    always #5 pclk = ~pclk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Reference model: one transfer in flight, how many bus cycles it has used, pending response.
    bit          m_busy;
    int          m_beats;
    int          m_waits;
    int          m_slave;
    bit          m_write;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_strb;
    logic [2:0]  m_prot;
    bit          m_rsp_v;
    logic [31:0] m_rsp_rdata;
    bit          m_rsp_err;
    bit          m_rsp_to;

    // Observations used by the directed literal checks.
    int          obs_acc[$];
    int          obs_rsp[$];
    logic [31:0] last_rdata;
    bit          last_err;
    bit          last_to;
    int          pen_cnt;
    int          psel_cnt;
    bit          rd_strb_seen;
    logic [31:0] last_paddr;
    logic [31:0] last_pwdata;
    logic [2:0]  last_psel;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clearObs();
        obs_acc.delete();
        obs_rsp.delete();
        last_rdata   = '0;
        last_err     = 1'b0;
        last_to      = 1'b0;
        pen_cnt      = 0;
        psel_cnt     = 0;
        rd_strb_seen = 1'b0;
        last_paddr   = '0;
        last_pwdata  = '0;
        last_psel    = '0;
    endtask

    task automatic applyStimulus(input bit v, input bit w, input logic [31:0] a,
                                 input logic [31:0] d, input logic [3:0] s, input logic [2:0] p);
        req_valid = v;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_strb  = s;
        req_prot  = p;
    endtask

    // Advance the model across one rising edge using the inputs currently driven.
    task automatic modelStep();
        int          idx;
        bit          nv;
        logic [31:0] nd;
        bit          ne;
        bit          nt;
        nv = 1'b0;
        nd = '0;
        ne = 1'b0;
        nt = 1'b0;
        if (!preset_n) begin
            m_busy  = 1'b0;
            m_rsp_v = 1'b0;
            return;
        end
        if (!m_busy) begin
            if (req_valid) begin
                idx = int'(req_addr[31:30]);
                if (idx >= NS) begin
                    nv = 1'b1;
                    ne = 1'b1;
                end else begin
                    m_busy  = 1'b1;
                    m_beats = 0;
                    m_waits = 0;
                    m_slave = idx;
                    m_write = req_write;
                    m_addr  = req_addr;
                    m_wdata = req_wdata;
                    m_strb  = req_strb;
                    m_prot  = req_prot;
                end
            end
        end else if (m_beats == 0) begin
            m_beats = 1;
        end else if (pready) begin
            nv     = 1'b1;
            nd     = m_write ? 32'h0 : prdata;
            ne     = pslverr;
            m_busy = 1'b0;
        end else begin
            m_waits++;
            m_beats++;
            if (m_waits == TO) begin
                nv     = 1'b1;
                nt     = 1'b1;
                m_busy = 1'b0;
            end
        end
        m_rsp_v     = nv;
        m_rsp_rdata = nd;
        m_rsp_err   = ne;
        m_rsp_to    = nt;
    endtask

    // Compare every DUT output against the model for the current cycle.
    task automatic checkOutput();
        logic [2:0] exp_sel;
        exp_sel = m_busy ? (3'b001 << m_slave) : 3'b000;
        chk("req_ready", req_ready, preset_n && !m_busy);
        chk("pselx", pselx, exp_sel);
        chk("penable", penable, m_busy && (m_beats > 0));
        chk("rsp_valid", rsp_valid, m_rsp_v);
        if (m_rsp_v) begin
            chk("rsp_rdata", rsp_rdata, m_rsp_rdata);
            chk("rsp_slverr", rsp_slverr, m_rsp_err);
            chk("rsp_timeout", rsp_timeout, m_rsp_to);
        end
        if (m_busy) begin
            chk("paddr", paddr, m_addr);
            chk("pwrite", pwrite, m_write);
            chk("pwdata", pwdata, m_write ? m_wdata : 32'h0);
            chk("pstrb", pstrb, m_write ? m_strb : 4'h0);
            chk("pprot", pprot, m_prot);
        end
        if (!preset_n) begin
            chk("rst_paddr", paddr, 0);
            chk("rst_pwdata", pwdata, 0);
            chk("rst_pstrb", pstrb, 0);
        end
        if (rsp_valid) begin
            obs_rsp.push_back(cyc);
            last_rdata = rsp_rdata;
            last_err   = rsp_slverr;
            last_to    = rsp_timeout;
        end
        if (penable) begin
            pen_cnt++;
            last_paddr  = paddr;
            last_pwdata = pwdata;
            last_psel   = pselx;
        end
        if (pselx != '0) psel_cnt++;
        if ((pselx != '0) && !pwrite && (pstrb != '0)) rd_strb_seen = 1'b1;
    endtask

    task automatic stepCycle();
        if (req_valid && req_ready && preset_n) obs_acc.push_back(cyc);
        modelStep();
        @(posedge pclk);
        cyc++;
        @(negedge pclk);
        checkOutput();
    endtask

    function automatic int latency(input int k);
        if ((obs_acc.size() <= k) || (obs_rsp.size() <= k)) return -1;
        return obs_rsp[k] - obs_acc[k];
    endfunction

    // One request, then a slave that raises pready after ready_after ACCESS cycles.
    task automatic runTransfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input int ready_after, input bit err,
                               input logic [31:0] rdval);
        clearObs();
        applyStimulus(1'b1, wr, addr, data, strb, 3'b010);
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = rdval;
        stepCycle();
        applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
        for (int i = 0; i < 40 && obs_rsp.size() == 0; i++) begin
            pready  = penable && (pen_cnt > ready_after);
            pslverr = err && pready;
            stepCycle();
        end
        chk("rsp_seen", obs_rsp.size(), 1);
        pready  = 1'b0;
        pslverr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        preset_n = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
        pready   = 1'b0;
        pslverr  = 1'b0;
        prdata   = '0;
        m_busy   = 1'b0;
        m_rsp_v  = 1'b0;
        m_beats  = 0;
        m_waits  = 0;
        m_slave  = 0;
        clearObs();
        repeat (2) @(negedge pclk);
        chk("reset_req_ready", req_ready, 0);
        chk("reset_pselx", pselx, 0);
        chk("reset_penable", penable, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        preset_n = 1'b1;
        #1;
        chk("release_req_ready", req_ready, 1);

        // Plain write with zero wait states.
        runTransfer(1'b1, 32'h0000_0010, 32'hA5A5_A5A5, 4'hF, 0, 1'b0, 32'h0);
        chk("wr_latency", latency(0), 3);
        chk("wr_slverr", last_err, 0);
        chk("wr_penable_cycles", pen_cnt, 1);
        chk("wr_paddr", last_paddr, 32'h10);
        chk("wr_pwdata", last_pwdata, 32'hA5A5_A5A5);

        // Read with three wait states.
        runTransfer(1'b0, 32'h0000_0020, 32'hFFFF_FFFF, 4'hF, 3, 1'b0, 32'h1234_5678);
        chk("rd_penable_cycles", pen_cnt, 4);
        chk("rd_rdata", last_rdata, 32'h1234_5678);
        chk("rd_pstrb_zero", rd_strb_seen, 0);
        chk("rd_pwdata_zero", last_pwdata, 0);
        chk("rd_latency", latency(0), 6);

        // Slave never ready: abort after TO ACCESS cycles.
        runTransfer(1'b0, 32'h4000_0004, 32'h0, 4'h0, 1000, 1'b0, 32'hDEAD_BEEF);
        chk("to_penable_cycles", pen_cnt, 16);
        chk("to_timeout", last_to, 1);
        chk("to_slverr", last_err, 0);
        chk("to_rdata", last_rdata, 0);
        chk("to_latency", latency(0), 18);
        chk("to_pselx_after", pselx, 0);
        chk("to_penable_after", penable, 0);

        // pready arrives in the very cycle the timeout would fire.
        runTransfer(1'b0, 32'h4000_0008, 32'h0, 4'h0, 15, 1'b0, 32'h0BAD_F00D);
        chk("edge_timeout", last_to, 0);
        chk("edge_rdata", last_rdata, 32'h0BAD_F00D);
        chk("edge_penable_cycles", pen_cnt, 16);

        // Decode error on slave index 3, then a slave error from slave 2.
        runTransfer(1'b1, 32'hC000_0000, 32'h1111_1111, 4'hF, 0, 1'b0, 32'h0);
        chk("dec_latency", latency(0), 1);
        chk("dec_slverr", last_err, 1);
        chk("dec_no_psel", psel_cnt, 0);
        runTransfer(1'b1, 32'h8000_0000, 32'h2222_2222, 4'h3, 0, 1'b1, 32'h0);
        chk("serr_slverr", last_err, 1);
        chk("serr_psel", last_psel, 3'b100);

        // Reset during ACCESS.
        clearObs();
        applyStimulus(1'b1, 1'b0, 32'h4000_0100, 32'h0, 4'h0, 3'b001);
        stepCycle();
        applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
        stepCycle();
        stepCycle();
        chk("pre_reset_penable", penable, 1);
        #2;
        preset_n = 1'b0;
        #1;
        chk("async_pselx", pselx, 0);
        chk("async_penable", penable, 0);
        chk("async_req_ready", req_ready, 0);
        chk("async_rsp_valid", rsp_valid, 0);
        chk("async_paddr", paddr, 0);
        @(negedge pclk);
        stepCycle();
        preset_n = 1'b1;
        #1;
        chk("post_reset_req_ready", req_ready, 1);
        clearObs();
        repeat (4) stepCycle();
        chk("reset_no_rsp", obs_rsp.size(), 0);

        // Back-to-back requests with a slave that is always ready.
        clearObs();
        applyStimulus(1'b1, 1'b1, 32'h0000_0100, 32'h3333_3333, 4'hF, 3'b000);
        for (int i = 0; i < 20 && obs_rsp.size() < 2; i++) begin
            if (obs_acc.size() == 1) applyStimulus(1'b1, 1'b0, 32'h4000_0200, 32'h0, 4'h0, 3'b100);
            if (obs_acc.size() >= 2) applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
            pready  = penable;
            pslverr = 1'b0;
            prdata  = 32'hCAFE_0000 + 32'(i);
            stepCycle();
        end
        applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
        chk("b2b_accepts", obs_acc.size(), 2);
        chk("b2b_no_gap", (obs_acc.size() == 2 && obs_rsp.size() >= 1) ? (obs_acc[1] - obs_rsp[0]) : -1, 0);
        chk("b2b_second_latency", latency(1), 3);

        // Random traffic with alternating free-running and stalling slave phases.
        clearObs();
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1, $urandom,
                          $urandom, 4'($urandom), 3'($urandom));
            if (((i / 60) % 3) == 2) pready = ($urandom_range(0, 19) == 0);
            else                     pready = ($urandom_range(0, 2) != 0);
            pslverr = ($urandom_range(0, 3) == 0);
            prdata  = $urandom;
            stepCycle();
        end
        applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
        pready = 1'b1;
        repeat (25) stepCycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
